// File: rtl/jt49_exp_sched.sv
// jt49_exp_sched: time-shares one jt49_exp volume LUT between PSG channels A, B and C.
// A request is snapshotted, issued to the LUT one channel per cycle, and the tagged returns are published together.
module jt49_exp_sched #(
  parameter int LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] comp,
  input  logic [4:0] vol_a,
  input  logic [4:0] vol_b,
  input  logic [4:0] vol_c,
  input  logic       ovr_clr,
  output logic [2:0] lut_comp,
  output logic [4:0] lut_din,
  input  logic [7:0] lut_dout,
  output logic [7:0] amp_a,
  output logic [7:0] amp_b,
  output logic [7:0] amp_c,
  output logic [9:0] mix,
  output logic       amp_valid,
  output logic       busy,
  output logic       ovr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [7:0] LAST_DRAIN = 8'(LAT);

  state_t     state, state_next;
  logic [7:0] cnt, cnt_next;
  logic       launch, issue_b, issue_c, publish;
  logic       pending, pending_next, ovr_next;
  logic [2:0] comp_clamped;
  logic [4:0] snap_b, snap_c;
  logic [7:0] hold_a, hold_b, hold_c;

  // Tag pipe: tag_v[i]/tag_idx[i] describe the LUT read issued i+1 edges ago.
  logic [LAT:0]      tag_v;
  logic [LAT:0][1:0] tag_idx;

  assign busy         = (state != IDLE);
  assign comp_clamped = (comp > 3'd4) ? 3'd4 : comp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    launch     = 1'b0;
    issue_b    = 1'b0;
    issue_c    = 1'b0;
    publish    = 1'b0;
    case (state)
      IDLE: begin
        if (start || pending) begin
          launch     = 1'b1;
          state_next = ISSUE;
          cnt_next   = 8'd0;
        end
      end
      ISSUE: begin
        if (cnt == 8'd0) begin
          issue_b  = 1'b1;
          cnt_next = 8'd1;
        end else if (cnt == 8'd1) begin
          issue_c  = 1'b1;
          cnt_next = 8'd2;
        end else begin
          state_next = DRAIN;
          cnt_next   = 8'd0;
        end
      end
      DRAIN: begin
        if (cnt == LAST_DRAIN) begin
          publish    = 1'b1;
          state_next = IDLE;
          cnt_next   = 8'd0;
        end else begin
          cnt_next = cnt + 8'd1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 8'd0;
      end
    endcase
  end

  // A start arriving together with a pending launch stays queued rather than being lost.
  always_comb begin
    pending_next = pending;
    ovr_next     = ovr;
    if (launch) begin
      pending_next = pending & start;
    end else if (busy && start) begin
      pending_next = 1'b1;
    end
    if (busy && start && pending) begin
      ovr_next = 1'b1;
    end else if (ovr_clr) begin
      ovr_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
      ovr     <= 1'b0;
    end else begin
      pending <= pending_next;
      ovr     <= ovr_next;
    end
  end

  // lut_din doubles as the channel A snapshot and lut_comp as the comp snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lut_din  <= 5'd0;
      lut_comp <= 3'd0;
      snap_b   <= 5'd0;
      snap_c   <= 5'd0;
    end else if (launch) begin
      lut_din  <= vol_a;
      lut_comp <= comp_clamped;
      snap_b   <= vol_b;
      snap_c   <= vol_c;
    end else if (issue_b) begin
      lut_din <= snap_b;
    end else if (issue_c) begin
      lut_din <= snap_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v   <= '0;
      tag_idx <= '0;
    end else begin
      tag_v[0]   <= launch | issue_b | issue_c;
      tag_idx[0] <= issue_b ? 2'd1 : (issue_c ? 2'd2 : 2'd0);
      for (int i = 1; i <= LAT; i++) begin
        tag_v[i]   <= tag_v[i-1];
        tag_idx[i] <= tag_idx[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_a <= 8'd0;
      hold_b <= 8'd0;
      hold_c <= 8'd0;
    end else if (tag_v[LAT]) begin
      case (tag_idx[LAT])
        2'd0:    hold_a <= lut_dout;
        2'd1:    hold_b <= lut_dout;
        2'd2:    hold_c <= lut_dout;
        default: hold_a <= hold_a;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      amp_a     <= 8'd0;
      amp_b     <= 8'd0;
      amp_c     <= 8'd0;
      mix       <= 10'd0;
      amp_valid <= 1'b0;
    end else begin
      amp_valid <= publish;
      if (publish) begin
        amp_a <= hold_a;
        amp_b <= hold_b;
        amp_c <= hold_c;
        mix   <= {2'b00, hold_a} + {2'b00, hold_b} + {2'b00, hold_c};
      end
    end
  end

endmodule

// File: tb/tb_jt49_exp_sched.sv
// Bench for jt49_exp_sched: LAT=1 and LAT=2 instances share stimulus, each fed by a
// behavioural jt49_exp LUT model with matching read latency.
module tb_jt49_exp_sched;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [2:0] comp;
  logic [4:0] vol_a, vol_b, vol_c;
  logic       ovr_clr;

  logic [2:0] d1_lut_comp, d2_lut_comp;
  logic [4:0] d1_lut_din, d2_lut_din;
  logic [7:0] d1_lut_dout, d2_lut_dout, d2_stage;
  logic [7:0] d1_amp_a, d1_amp_b, d1_amp_c, d2_amp_a, d2_amp_b, d2_amp_c;
  logic [9:0] d1_mix, d2_mix;
  logic       d1_amp_valid, d2_amp_valid, d1_busy, d2_busy, d1_ovr, d2_ovr;

  int checks   = 0;
  int failures = 0;

  jt49_exp_sched #(.LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .comp(comp),
    .vol_a(vol_a), .vol_b(vol_b), .vol_c(vol_c), .ovr_clr(ovr_clr),
    .lut_comp(d1_lut_comp), .lut_din(d1_lut_din), .lut_dout(d1_lut_dout),
    .amp_a(d1_amp_a), .amp_b(d1_amp_b), .amp_c(d1_amp_c), .mix(d1_mix),
    .amp_valid(d1_amp_valid), .busy(d1_busy), .ovr(d1_ovr)
  );

  jt49_exp_sched #(.LAT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .comp(comp),
    .vol_a(vol_a), .vol_b(vol_b), .vol_c(vol_c), .ovr_clr(ovr_clr),
    .lut_comp(d2_lut_comp), .lut_din(d2_lut_din), .lut_dout(d2_lut_dout),
    .amp_a(d2_amp_a), .amp_b(d2_amp_b), .amp_c(d2_amp_c), .mix(d2_mix),
    .amp_valid(d2_amp_valid), .busy(d2_busy), .ovr(d2_ovr)
  );

  // jt49_exp model: comp=0 curve in full, the other points the tests rely on, and a
  // comp-dependent filler elsewhere so a wrong comp or index shows up as a wrong amplitude.
  function automatic logic [7:0] lut_f(input logic [2:0] c, input logic [4:0] d);
    logic [7:0] t0 [32];
    t0 = '{8'd0, 8'd1, 8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7,
           8'd9, 8'd11, 8'd13, 8'd15, 8'd18, 8'd22, 8'd26, 8'd31, 8'd37, 8'd44,
           8'd53, 8'd63, 8'd75, 8'd90, 8'd107, 8'd127, 8'd151, 8'd180, 8'd214, 8'd255};
    if (d == 5'd0) return 8'd0;
    if (d == 5'd31) return 8'd255;
    if (c == 3'd0) return t0[d];
    if (c == 3'd3 && d == 5'd1) return 8'd51;
    if (c == 3'd4 && d == 5'd12) return 8'd64;
    return 8'(int'(d) * 7 + int'(c) * 3);
  endfunction

  always @(posedge clk) d1_lut_dout <= lut_f(d1_lut_comp, d1_lut_din);

  always @(posedge clk) begin
    d2_stage    <= lut_f(d2_lut_comp, d2_lut_din);
    d2_lut_dout <= d2_stage;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drives one start pulse; returns at 1 time unit after the edge that sees it.
  task automatic pulse_start(input logic [2:0] c, input logic [4:0] a, input logic [4:0] b,
                             input logic [4:0] cc);
    @(posedge clk); #1;
    comp  = c;
    vol_a = a;
    vol_b = b;
    vol_c = cc;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Runs one sequence on idle DUTs; lat is the cycle count to amp_valid on dut1, -1 on timeout.
  task automatic run_seq(input logic [2:0] c, input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] cc, output int lat, output logic [2:0] comp_seen);
    lat = -1;
    pulse_start(c, a, b, cc);
    comp_seen = d1_lut_comp;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (d1_amp_valid) begin
        lat = i;
        break;
      end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [44:0] s1, s2;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    s1 = {d1_amp_a, d1_amp_b, d1_amp_c, d1_mix, d1_lut_din, d1_lut_comp, d1_amp_valid, d1_busy, d1_ovr};
    s2 = {d2_amp_a, d2_amp_b, d2_amp_c, d2_mix, d2_lut_din, d2_lut_comp, d2_amp_valid, d2_busy, d2_ovr};
    checks++;
    if (s1 !== 45'd0) begin failures++; $display("FAIL reset_lat1 got=%h exp=0", s1); end
    checks++;
    if (s2 !== 45'd0) begin failures++; $display("FAIL reset_lat2 got=%h exp=0", s2); end
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    s1 = {d1_amp_a, d1_amp_b, d1_amp_c, d1_mix, d1_lut_din, d1_lut_comp, d1_amp_valid, d1_busy, d1_ovr};
    checks++;
    if (s1 !== 45'd0) begin failures++; $display("FAIL idle_after_reset got=%h exp=0", s1); end
  endtask

  task automatic test_basic;
    int lat1, lat2, busy_cnt, valid_cnt;
    logic [14:0] din_seq;
    logic [8:0]  comp_seq;
    lat1 = -1; lat2 = -1; busy_cnt = 0; valid_cnt = 0;
    din_seq = '0; comp_seq = '0;
    pulse_start(3'd0, 5'd31, 5'd16, 5'd0);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      if (d1_busy) busy_cnt++;
      if (d1_amp_valid) valid_cnt++;
      if (d1_amp_valid && lat1 < 0) lat1 = i;
      if (d2_amp_valid && lat2 < 0) lat2 = i;
      if (i < 3) begin
        din_seq  = {din_seq[9:0], d1_lut_din};
        comp_seq = {comp_seq[5:0], d1_lut_comp};
      end
    end
    checks++;
    if (din_seq !== {5'd31, 5'd16, 5'd0}) begin failures++; $display("FAIL basic_lut_din got=%h exp=%h", din_seq, {5'd31, 5'd16, 5'd0}); end
    checks++;
    if (comp_seq !== 9'd0) begin failures++; $display("FAIL basic_lut_comp got=%h exp=0", comp_seq); end
    checks++;
    if (lat1 !== 5) begin failures++; $display("FAIL basic_latency_lat1 got=%0d exp=5", lat1); end
    checks++;
    if (lat2 !== 6) begin failures++; $display("FAIL basic_latency_lat2 got=%0d exp=6", lat2); end
    checks++;
    if (busy_cnt !== 5) begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=5", busy_cnt); end
    checks++;
    if (valid_cnt !== 1) begin failures++; $display("FAIL basic_valid_pulses got=%0d exp=1", valid_cnt); end
    checks++;
    if ({d1_amp_a, d1_amp_b, d1_amp_c} !== {8'd255, 8'd18, 8'd0})
      begin failures++; $display("FAIL basic_amps_lat1 got=%0d/%0d/%0d exp=255/18/0", d1_amp_a, d1_amp_b, d1_amp_c); end
    checks++;
    if (d1_mix !== 10'd273) begin failures++; $display("FAIL basic_mix_lat1 got=%0d exp=273", d1_mix); end
    checks++;
    if ({d2_amp_a, d2_amp_b, d2_amp_c} !== {8'd255, 8'd18, 8'd0})
      begin failures++; $display("FAIL basic_amps_lat2 got=%0d/%0d/%0d exp=255/18/0", d2_amp_a, d2_amp_b, d2_amp_c); end
    checks++;
    if (d2_mix !== 10'd273) begin failures++; $display("FAIL basic_mix_lat2 got=%0d exp=273", d2_mix); end
  endtask

  task automatic test_values;
    int lat;
    logic [2:0] cs;
    run_seq(3'd3, 5'd1, 5'd1, 5'd1, lat, cs);
    checks++;
    if (lat !== 5) begin failures++; $display("FAIL comp3_latency got=%0d exp=5", lat); end
    checks++;
    if ({d1_amp_a, d1_amp_b, d1_amp_c} !== {8'd51, 8'd51, 8'd51})
      begin failures++; $display("FAIL comp3_amps got=%0d/%0d/%0d exp=51/51/51", d1_amp_a, d1_amp_b, d1_amp_c); end
    checks++;
    if (d1_mix !== 10'd153) begin failures++; $display("FAIL comp3_mix got=%0d exp=153", d1_mix); end
    run_seq(3'd7, 5'd12, 5'd0, 5'd0, lat, cs);
    checks++;
    if (cs !== 3'd4) begin failures++; $display("FAIL comp7_clamp got=%0d exp=4", cs); end
    checks++;
    if (d1_amp_a !== 8'd64) begin failures++; $display("FAIL comp7_amp_a got=%0d exp=64", d1_amp_a); end
    run_seq(3'd4, 5'd31, 5'd31, 5'd31, lat, cs);
    checks++;
    if (d1_mix !== 10'd765) begin failures++; $display("FAIL full_scale_mix got=%0d exp=765", d1_mix); end
    checks++;
    if ({d1_amp_a, d1_amp_b, d1_amp_c} !== {8'd255, 8'd255, 8'd255})
      begin failures++; $display("FAIL full_scale_amps got=%0d/%0d/%0d exp=255/255/255", d1_amp_a, d1_amp_b, d1_amp_c); end
  endtask

  task automatic test_back_to_back;
    int p1, p2, pulses;
    logic [33:0] r1, r2;
    p1 = -1; p2 = -1; pulses = 0; r1 = '0; r2 = '0;
    pulse_start(3'd0, 5'd31, 5'd16, 5'd0);
    @(posedge clk); #1;
    comp = 3'd3; vol_a = 5'd1; vol_b = 5'd1; vol_c = 5'd1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // The queued launch must use whatever is present at its own launch edge.
    comp = 3'd4; vol_a = 5'd12; vol_b = 5'd0; vol_c = 5'd31;
    for (int i = 3; i <= 20; i++) begin
      @(posedge clk); #1;
      if (d1_amp_valid) begin
        pulses++;
        if (p1 < 0) begin
          p1 = i;
          r1 = {d1_amp_a, d1_amp_b, d1_amp_c, d1_mix};
        end else if (p2 < 0) begin
          p2 = i;
          r2 = {d1_amp_a, d1_amp_b, d1_amp_c, d1_mix};
        end
      end
    end
    checks++;
    if (p1 !== 5 || p2 !== 11) begin failures++; $display("FAIL b2b_pulse_cycles got=%0d,%0d exp=5,11", p1, p2); end
    checks++;
    if (pulses !== 2) begin failures++; $display("FAIL b2b_pulse_count got=%0d exp=2", pulses); end
    checks++;
    if (r1 !== {8'd255, 8'd18, 8'd0, 10'd273}) begin failures++; $display("FAIL b2b_first_result got=%h exp=%h", r1, {8'd255, 8'd18, 8'd0, 10'd273}); end
    checks++;
    if (r2 !== {8'd64, 8'd0, 8'd255, 10'd319}) begin failures++; $display("FAIL b2b_second_result got=%h exp=%h", r2, {8'd64, 8'd0, 8'd255, 10'd319}); end
    checks++;
    if (d1_ovr !== 1'b0) begin failures++; $display("FAIL b2b_ovr got=%b exp=0", d1_ovr); end
  endtask

  task automatic test_overflow;
    int pulses;
    pulses = 0;
    pulse_start(3'd0, 5'd1, 5'd2, 5'd3);
    start = 1'b1;                // seen while busy: becomes pending
    @(posedge clk); #1;          // still high: dropped
    @(posedge clk); #1;
    checks++;
    if (d1_ovr !== 1'b1) begin failures++; $display("FAIL ovr_set got=%b exp=1", d1_ovr); end
    ovr_clr = 1'b1;              // lost start and clear together
    @(posedge clk); #1;
    start = 1'b0;
    ovr_clr = 1'b0;
    checks++;
    if (d1_ovr !== 1'b1) begin failures++; $display("FAIL ovr_set_wins got=%b exp=1", d1_ovr); end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (d1_amp_valid) pulses++;
    end
    checks++;
    if (pulses !== 2) begin failures++; $display("FAIL ovr_pulse_count got=%0d exp=2", pulses); end
    checks++;
    if (d1_ovr !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%b exp=1", d1_ovr); end
    ovr_clr = 1'b1;
    @(posedge clk); #1;
    ovr_clr = 1'b0;
    checks++;
    if (d1_ovr !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%b exp=0", d1_ovr); end
  endtask

  task automatic test_snapshot;
    int lat;
    logic [2:0] comp_mid;
    lat = -1;
    pulse_start(3'd0, 5'd31, 5'd16, 5'd0);
    vol_a = 5'd0;
    comp  = 3'd3;
    @(posedge clk); #1;
    comp_mid = d1_lut_comp;
    for (int i = 2; i <= 20; i++) begin
      @(posedge clk); #1;
      if (d1_amp_valid) begin
        lat = i;
        break;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (comp_mid !== 3'd0) begin failures++; $display("FAIL snap_lut_comp got=%0d exp=0", comp_mid); end
    checks++;
    if (lat !== 5) begin failures++; $display("FAIL snap_latency got=%0d exp=5", lat); end
    checks++;
    if ({d1_amp_a, d1_amp_b, d1_amp_c, d1_mix} !== {8'd255, 8'd18, 8'd0, 10'd273})
      begin failures++; $display("FAIL snap_result got=%0d/%0d/%0d/%0d exp=255/18/0/273", d1_amp_a, d1_amp_b, d1_amp_c, d1_mix); end
  endtask

  task automatic test_async_reset;
    int pulses, lat;
    logic [2:0] cs;
    logic [44:0] s1;
    pulses = 0;
    pulse_start(3'd3, 5'd1, 5'd1, 5'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    s1 = {d1_amp_a, d1_amp_b, d1_amp_c, d1_mix, d1_lut_din, d1_lut_comp, d1_amp_valid, d1_busy, d1_ovr};
    checks++;
    if (s1 !== 45'd0) begin failures++; $display("FAIL midseq_reset_clear got=%h exp=0", s1); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (d1_amp_valid || d1_busy) pulses++;
    end
    checks++;
    if (pulses !== 0) begin failures++; $display("FAIL midseq_no_valid got=%0d exp=0", pulses); end
    run_seq(3'd3, 5'd1, 5'd1, 5'd1, lat, cs);
    checks++;
    if (lat !== 5) begin failures++; $display("FAIL post_reset_latency got=%0d exp=5", lat); end
    checks++;
    if ({d1_amp_a, d1_amp_b, d1_amp_c, d1_mix} !== {8'd51, 8'd51, 8'd51, 10'd153})
      begin failures++; $display("FAIL post_reset_result got=%0d/%0d/%0d/%0d exp=51/51/51/153", d1_amp_a, d1_amp_b, d1_amp_c, d1_mix); end
  endtask

  initial begin
    start   = 1'b0;
    comp    = 3'd0;
    vol_a   = 5'd0;
    vol_b   = 5'd0;
    vol_c   = 5'd0;
    ovr_clr = 1'b0;
    test_reset();
    test_basic();
    test_values();
    test_back_to_back();
    test_overflow();
    test_snapshot();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
